// File: rtl/control_pkg.sv
// control_pkg: opcodes, FSM states and accumulator-source selects
// shared by the control_sequencer slice.
package control_pkg;

  typedef enum logic [4:0] {
    OP_HLT  = 5'h00,
    OP_STO  = 5'h01,
    OP_LDA  = 5'h02,
    OP_LDI  = 5'h03,
    OP_ADD  = 5'h04,
    OP_ADDI = 5'h05,
    OP_SUB  = 5'h06,
    OP_SUBI = 5'h07,
    OP_JMP  = 5'h08,
    OP_BEQ  = 5'h09,
    OP_BNE  = 5'h0A,
    OP_BLT  = 5'h0B,
    OP_BGE  = 5'h0C,
    OP_CALL = 5'h0D,
    OP_RET  = 5'h0E
  } opcode_t;

  typedef enum logic [1:0] {
    FETCH,
    DECODE,
    EXECUTE,
    HALT
  } state_t;

  localparam logic [1:0] SEL_A_MEM = 2'b00;
  localparam logic [1:0] SEL_A_ALU = 2'b01;
  localparam logic [1:0] SEL_A_IMM = 2'b10;

endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: instruction-fetch req/ack handshake between
// the sequencer (master) and instruction memory (slave).
interface control_sequencer_if #(
  parameter int OPERAND_WIDTH     = 11,
  parameter int INSTRUCTION_WIDTH = 16
);
  logic [OPERAND_WIDTH-1:0]     address_out;
  logic                         imem_req_out;
  logic [INSTRUCTION_WIDTH-1:0] instruction_in;
  logic                         imem_ack_in;

  modport master (
    output address_out,
    output imem_req_out,
    input  instruction_in,
    input  imem_ack_in
  );

  modport slave (
    input  address_out,
    input  imem_req_out,
    output instruction_in,
    output imem_ack_in
  );
endinterface

// File: rtl/control_sequencer_return_stack.sv
// return_stack: small LIFO of return addresses; push on full and
// pop on empty are ignored so the caller can flag the error.
module return_stack #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;

  assign full   = cnt == CW'(DEPTH);
  assign empty  = cnt == '0;
  assign wr_idx = AW'(cnt);
  assign rd_idx = AW'(cnt - CW'(1));
  assign top    = empty ? '0 : mem[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + CW'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= din;
    end
  end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: FETCH/DECODE/EXECUTE controller for the accumulator
// CPU; CONTROL_STACK_EN enables the CALL/RET return-address stack.
module control_sequencer
  import control_pkg::*;
#(
  parameter int OPERAND_WIDTH     = 11,
  parameter int INSTRUCTION_WIDTH = 16,
  parameter int STACK_DEPTH       = 4
) (
  input  logic                     clock_in,
  input  logic                     reset_in,
  control_sequencer_if.master      imem,
  input  logic                     status_Z_in,
  input  logic                     status_N_in,
  output logic [OPERAND_WIDTH-1:0] operand_out,
  output logic [1:0]               sel_A_out,
  output logic                     sel_B_out,
  output logic                     alu_op_out,
  output logic                     data_memory_wr_out,
  output logic                     acc_wr_out,
  output logic                     status_wr_out,
  output logic                     acc_reset_out,
  output logic                     status_reset_out,
  output logic                     halted_out,
  output logic                     stack_err_out
);
  localparam int OW = OPERAND_WIDTH;
  localparam int IW = INSTRUCTION_WIDTH;

  if (IW - OW < 5) begin : g_bad_opcode_width
    $error("opcode field must be at least 5 bits");
  end
  if (STACK_DEPTH < 2) begin : g_bad_stack_depth
    $error("STACK_DEPTH must be at least 2");
  end

  state_t        state;
  logic [OW-1:0] pc;
  logic [IW-1:0] ir;
  logic [4:0]    op;

  logic is_hlt, is_sto, is_lda, is_ldi;
  logic is_add, is_addi, is_sub, is_subi;
  logic is_load, is_alu, take;
  logic is_call, is_ret, stk_full, stk_empty;
  logic [OW-1:0] stk_top;
  logic stk_fault;

  assign op      = ir[OW +: 5];
  assign is_hlt  = op == OP_HLT;
  assign is_sto  = op == OP_STO;
  assign is_lda  = op == OP_LDA;
  assign is_ldi  = op == OP_LDI;
  assign is_add  = op == OP_ADD;
  assign is_addi = op == OP_ADDI;
  assign is_sub  = op == OP_SUB;
  assign is_subi = op == OP_SUBI;
  assign is_load = is_lda | is_ldi;
  assign is_alu  = is_add | is_addi | is_sub | is_subi;

  assign take = (op == OP_JMP)
    | ((op == OP_BEQ) & status_Z_in)
    | ((op == OP_BNE) & !status_Z_in)
    | ((op == OP_BLT) & status_N_in)
    | ((op == OP_BGE) & !status_N_in);

`ifdef CONTROL_STACK_EN
  assign is_call = op == OP_CALL;
  assign is_ret  = op == OP_RET;

  return_stack #(
    .WIDTH (OW),
    .DEPTH (STACK_DEPTH)
  ) u_return_stack (
    .clk   (clock_in),
    .rst_n (reset_in),
    .push  (state == EXECUTE && is_call),
    .pop   (state == EXECUTE && is_ret),
    .din   (pc),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );
`else
  assign is_call   = 1'b0;
  assign is_ret    = 1'b0;
  assign stk_full  = 1'b0;
  assign stk_empty = 1'b1;
  assign stk_top   = '0;
`endif

  assign stk_fault = (is_call & stk_full) | (is_ret & stk_empty);

  // HLT never needs an execute cycle, so it halts straight from DECODE.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state         <= FETCH;
      pc            <= '0;
      ir            <= '0;
      halted_out    <= 1'b0;
      stack_err_out <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          if (imem.imem_ack_in) begin
            ir    <= imem.instruction_in;
            pc    <= pc + OW'(1);
            state <= DECODE;
          end
        end
        DECODE: begin
          if (is_hlt) begin
            state      <= HALT;
            halted_out <= 1'b1;
          end else begin
            state <= EXECUTE;
          end
        end
        EXECUTE: begin
          state <= FETCH;
          if (stk_fault) begin
            state         <= HALT;
            halted_out    <= 1'b1;
            stack_err_out <= 1'b1;
          end else if (is_ret) begin
            pc <= stk_top;
          end else if (is_call || take) begin
            pc <= ir[OW-1:0];
          end
        end
        HALT: begin
          state <= HALT;
        end
      endcase
    end
  end

  assign imem.address_out  = pc;
  assign imem.imem_req_out = reset_in && (state == FETCH);
  assign operand_out       = ir[OW-1:0];
  assign acc_reset_out     = !reset_in;
  assign status_reset_out  = !reset_in;

  always_comb begin
    sel_A_out          = SEL_A_MEM;
    sel_B_out          = 1'b0;
    alu_op_out         = 1'b0;
    data_memory_wr_out = 1'b0;
    acc_wr_out         = 1'b0;
    status_wr_out      = 1'b0;
    if (state == DECODE || state == EXECUTE) begin
      unique case (1'b1)
        is_lda:  sel_A_out = SEL_A_MEM;
        is_ldi:  sel_A_out = SEL_A_IMM;
        is_add:  sel_A_out = SEL_A_ALU;
        is_addi: begin
          sel_A_out = SEL_A_ALU;
          sel_B_out = 1'b1;
        end
        is_sub: begin
          sel_A_out  = SEL_A_ALU;
          alu_op_out = 1'b1;
        end
        is_subi: begin
          sel_A_out  = SEL_A_ALU;
          sel_B_out  = 1'b1;
          alu_op_out = 1'b1;
        end
        default: ;
      endcase
      if (state == EXECUTE) begin
        acc_wr_out         = is_load | is_alu;
        status_wr_out      = is_load | is_alu;
        data_memory_wr_out = is_sto;
      end
    end
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed and random programs against an
// instruction-level model that expands each instruction into cycles.
module tb_control_sequencer;
  localparam int OW    = 11;
  localparam int IW    = 16;
  localparam int DEPTH = 4;

  localparam logic [4:0] HLT = 5'h00, STO = 5'h01, LDA = 5'h02;
  localparam logic [4:0] LDI = 5'h03, ADD = 5'h04, ADDI = 5'h05;
  localparam logic [4:0] SUB = 5'h06, SUBI = 5'h07, JMP = 5'h08;
  localparam logic [4:0] BEQ = 5'h09, BNE = 5'h0A, BLT = 5'h0B;
  localparam logic [4:0] BGE = 5'h0C, CALL = 5'h0D, RET = 5'h0E;
  localparam logic [4:0] NOP = 5'h1F;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic z = 1'b0;
  logic n = 1'b0;

  logic [OW-1:0] operand;
  logic [1:0]    sel_a;
  logic sel_b, alu_op, dm_wr, acc_wr, st_wr;
  logic acc_rst, st_rst, halted, stk_err;

  control_sequencer_if #(
    .OPERAND_WIDTH     (OW),
    .INSTRUCTION_WIDTH (IW)
  ) mif ();

  control_sequencer #(
    .OPERAND_WIDTH     (OW),
    .INSTRUCTION_WIDTH (IW),
    .STACK_DEPTH       (DEPTH)
  ) dut (
    .clock_in           (clk),
    .reset_in           (rst_n),
    .imem               (mif),
    .status_Z_in        (z),
    .status_N_in        (n),
    .operand_out        (operand),
    .sel_A_out          (sel_a),
    .sel_B_out          (sel_b),
    .alu_op_out         (alu_op),
    .data_memory_wr_out (dm_wr),
    .acc_wr_out         (acc_wr),
    .status_wr_out      (st_wr),
    .acc_reset_out      (acc_rst),
    .status_reset_out   (st_rst),
    .halted_out         (halted),
    .stack_err_out      (stk_err)
  );

  always #5 clk = ~clk;

  logic [IW-1:0] prog [2**OW];
  int wait_states = 0;
  int wcnt = 0;
  int checks = 0;
  int errors = 0;
  logic [20:0] exp_q [$];
  logic [20:0] obs_v;

  assign obs_v = {mif.imem_req_out, mif.address_out, sel_a, sel_b,
                  alu_op, acc_wr, st_wr, dm_wr, halted, stk_err};

  // Instruction memory: acks after wait_states idle request cycles.
  always @(negedge clk) begin
    if (mif.imem_req_out) begin
      if (wcnt >= wait_states) begin
        mif.imem_ack_in = 1'b1;
        mif.instruction_in = prog[mif.address_out];
        wcnt = 0;
      end else begin
        mif.imem_ack_in = 1'b0;
        wcnt++;
      end
    end else begin
      mif.imem_ack_in = 1'b0;
      wcnt = 0;
    end
  end

  function automatic logic [20:0] vec(
    logic req, logic [10:0] a, logic [1:0] sa, logic sb, logic alu,
    logic aw, logic dw, logic h, logic e);
    return {req, a, sa, sb, alu, aw, aw, dw, h, e};
  endfunction

  function automatic logic [15:0] ins(logic [4:0] o, logic [10:0] d);
    return {o, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 2**OW; i++) prog[i] = ins(NOP, 11'd0);
  endtask

  task automatic build_model(input int ncyc, input int waits);
    logic [10:0] pc, pcn, npc, opnd;
    logic [4:0]  op;
    logic [1:0]  sa;
    logic sb, alu, aw, dw, fault;
    logic [10:0] stk [$];
    exp_q.delete();
    pc = '0;
    while (exp_q.size() < ncyc) begin
      op = prog[pc][15:11];
      opnd = prog[pc][10:0];
      pcn = pc + 11'd1;
      npc = pcn;
      sa = 2'd0; sb = 0; alu = 0; aw = 0; dw = 0; fault = 0;
      case (op)
        LDA:  aw = 1;
        LDI:  begin sa = 2'd2; aw = 1; end
        ADD:  begin sa = 2'd1; aw = 1; end
        ADDI: begin sa = 2'd1; sb = 1; aw = 1; end
        SUB:  begin sa = 2'd1; alu = 1; aw = 1; end
        SUBI: begin sa = 2'd1; sb = 1; alu = 1; aw = 1; end
        STO:  dw = 1;
        JMP:  npc = opnd;
        BEQ:  if (z) npc = opnd;
        BNE:  if (!z) npc = opnd;
        BLT:  if (n) npc = opnd;
        BGE:  if (!n) npc = opnd;
`ifdef CONTROL_STACK_EN
        CALL: if (stk.size() >= DEPTH) fault = 1;
              else begin stk.push_back(pcn); npc = opnd; end
        RET:  if (stk.size() == 0) fault = 1;
              else npc = stk.pop_back();
`endif
        default: ;
      endcase
      repeat (waits + 1) exp_q.push_back(vec(1, pc, 0, 0, 0, 0, 0, 0, 0));
      if (op == HLT) begin
        exp_q.push_back(vec(0, pcn, 0, 0, 0, 0, 0, 0, 0));
        while (exp_q.size() < ncyc)
          exp_q.push_back(vec(0, pcn, 0, 0, 0, 0, 0, 1, 0));
      end else begin
        exp_q.push_back(vec(0, pcn, sa, sb, alu, 0, 0, 0, 0));
        exp_q.push_back(vec(0, pcn, sa, sb, alu, aw, dw, 0, 0));
        if (fault)
          while (exp_q.size() < ncyc)
            exp_q.push_back(vec(0, pcn, 0, 0, 0, 0, 0, 1, 1));
        pc = npc;
      end
    end
  endtask

  // Cycle k (1-based) is sampled mid-cycle, just after the falling edge.
  task automatic run_prog(input string name, input int ncyc,
                          input int waits);
    build_model(ncyc, waits);
    wait_states = waits;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check({name, " reset_vec"}, 32'(obs_v), 32'd0);
    check({name, " reset_operand"}, 32'(operand), 32'd0);
    check({name, " reset_clr"}, 32'({acc_rst, st_rst}), 32'd3);
    #1 rst_n = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("%s cyc%0d", name, k + 1), 32'(obs_v),
            32'(exp_q[k]));
    end
  endtask

  initial begin
    clear_prog();
    prog[0] = ins(LDI, 11'd5);
    prog[1] = ins(ADDI, 11'd3);
    prog[2] = ins(STO, 11'h010);
    prog[3] = ins(HLT, 11'd0);
    run_prog("basic", 9, 0);
    check("basic sto_operand", 32'(operand), 32'h010);
    check("basic sto_strobe", 32'(dm_wr), 32'd1);
    run_prog("basic_full", 14, 0);
    check("basic halted", 32'(halted), 32'd1);
    run_prog("wait2", 22, 2);

    clear_prog();
    prog[0] = ins(BEQ, 11'h020);
    z = 1'b1;
    run_prog("beq_taken", 4, 0);
    check("beq_taken addr", 32'(mif.address_out), 32'h020);
    z = 1'b0;
    run_prog("beq_not", 4, 0);
    check("beq_not addr", 32'(mif.address_out), 32'h001);

    clear_prog();
    prog[5] = ins(CALL, 11'h040);
    prog[6] = ins(HLT, 11'd0);
    prog[11'h040] = ins(RET, 11'd0);
    run_prog("call_ret", 22, 1);
    run_prog("call_ret0", 22, 0);
`ifdef CONTROL_STACK_EN
    check("call_ret addr", 32'(mif.address_out), 32'h006);
`else
    check("call_ret nop", 32'({halted, mif.address_out}), 32'h807);
`endif

    clear_prog();
    for (int i = 0; i < 5; i++) prog[i] = ins(CALL, 11'(i + 1));
    prog[5] = ins(HLT, 11'd0);
    run_prog("overflow", 18, 0);
`ifdef CONTROL_STACK_EN
    check("overflow err", 32'({halted, stk_err}), 32'd3);
`else
    check("overflow err", 32'({halted, stk_err}), 32'd2);
`endif

    clear_prog();
    prog[0] = ins(RET, 11'd0);
    prog[1] = ins(HLT, 11'd0);
    run_prog("underflow", 6, 0);
`ifdef CONTROL_STACK_EN
    check("underflow err", 32'({halted, stk_err}), 32'd3);
`else
    check("underflow err", 32'({halted, stk_err}), 32'd2);
`endif

    clear_prog();
    prog[1] = ins(STO, 11'h010);
    run_prog("mid_reset", 6, 0);
    check("mid_reset strobe_before", 32'(dm_wr), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_reset strobe_drop", 32'(dm_wr), 32'd0);
    check("mid_reset vec", 32'(obs_v), 32'd0);
    check("mid_reset clr", 32'({acc_rst, st_rst}), 32'd3);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("mid_reset refetch", 32'({mif.imem_req_out, mif.address_out}),
          32'h800);

    for (int r = 0; r < 6; r++) begin
      clear_prog();
      for (int i = 0; i < 64; i++) begin
        if ($urandom_range(0, 99) < 3)
          prog[i] = ins(HLT, 11'($urandom_range(0, 63)));
        else
          prog[i] = ins(5'($urandom_range(1, 16)),
                        11'($urandom_range(0, 63)));
      end
      z = 1'($urandom_range(0, 1));
      n = 1'($urandom_range(0, 1));
      run_prog($sformatf("rand%0d", r), 80, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
# control_sequencer

Parametrised multi-cycle control unit for the accumulator CPU, successor to the fixed-width fetch/decode controller. It owns the program counter, instruction register and a FETCH/DECODE/EXECUTE state machine, drives the datapath select and write strobes, and adds three capabilities the previous controller lacks:
- a req/ack instruction-fetch handshake that tolerates memory wait states;
- a HALT state;
- an optional hardware return-address stack for CALL/RET.

## Interface
Parameters:
- OPERAND_WIDTH, 11, operand, data-address and PC width
- INSTRUCTION_WIDTH, 16, instruction width; opcode field = top INSTRUCTION_WIDTH-OPERAND_WIDTH bits, must be ≥5 (elaboration error otherwise)
- STACK_DEPTH, 4, return-stack entries (≥2)

Ports:
- clock_in  in  1  single clock, rising edge
- reset_in  in  1  asynchronous, active-low reset
- instruction_in  in  INSTRUCTION_WIDTH  fetched word, sampled when imem_ack_in=1 in FETCH
- imem_ack_in  in  1  fetch acknowledge, may arrive in the same cycle as the request
- status_Z_in, status_N_in  in  1 each  accumulator zero/negative flags
- address_out  out  OPERAND_WIDTH  PC (instruction address)
- imem_req_out  out  1  fetch request
- operand_out  out  OPERAND_WIDTH  IR operand field (data address / immediate / target)
- sel_A_out  out  2  accumulator source: 00 data mem, 01 ALU, 10 immediate
- sel_B_out  out  1  ALU B: 0 data mem, 1 immediate
- alu_op_out  out  1  0 add, 1 sub
- data_memory_wr_out, acc_wr_out, status_wr_out  out  1 each  write strobes
- acc_reset_out, status_reset_out  out  1 each  =1 while reset_in low
- halted_out  out  1  in HALT
- stack_err_out  out  1  sticky stack overflow/underflow

## Operation
- Opcodes (5 LSBs of opcode field; upper opcode bits ignored):
  - 00 HLT, 01 STO, 02 LDA, 03 LDI, 04 ADD, 05 ADDI, 06 SUB, 07 SUBI
  - 08 JMP, 09 BEQ (Z), 0A BNE (!Z), 0B BLT (N), 0C BGE (!N)
  - 0D CALL, 0E RET
  - all others NOP
- States: FETCH → DECODE → EXECUTE → FETCH. HLT, overflow and underflow go to HALT.
- FETCH:
  - imem_req_out=1, address_out=PC.
  - On imem_ack_in: IR←instruction_in, PC←PC+1 (wraps mod 2^OPERAND_WIDTH), go to DECODE.
  - Without ack: stay in FETCH; PC and IR hold.
- DECODE:
  - One cycle; operand_out stable so synchronous data memory can read.
  - sel_A/sel_B/alu_op driven from the IR; they are 0 in FETCH and HALT.
- EXECUTE (one cycle; strobes pulse here only, for exactly one cycle):
  - LDA/LDI: acc_wr, status_wr; sel_A 00/10.
  - ADD/SUB/ADDI/SUBI: sel_A=01, sel_B 0/0/1/1, alu_op 0/1/0/1, acc_wr, status_wr.
  - STO: data_memory_wr_out only.
  - Branches: flags sampled in EXECUTE; if taken, PC←operand.
  - CALL: push PC (already incremented), PC←operand.
  - RET: PC←pop.
- Stack boundary conditions:
  - CALL when full: no push, stack_err_out←1, HALT.
  - RET when empty: no pop, stack_err_out←1, HALT.
- HALT: halted_out=1, all strobes 0, imem_req_out=0. Left only by reset.
- Reset (also mid-fetch or mid-execute): PC=0, IR=0, stack empty, stack_err_out=0, state FETCH, all outputs 0 except acc_reset_out/status_reset_out=1.

## Timing
- Minimum 3 cycles per instruction with same-cycle ack. Each wait state adds 1 cycle in FETCH.
- After reset release, imem_req_out=1 with address_out=0 in the first cycle.
- Taken branch, CALL or RET: new PC visible on address_out in the cycle following EXECUTE.
- Registered outputs: address_out, operand_out, halted_out, stack_err_out. Select and strobe outputs are combinational from state and IR.

## Configuration
- CONTROL_STACK_EN defined: the return_stack is instantiated and CALL/RET behave as above.
- Undefined: CALL/RET decode as NOP, there is no stack storage, and stack_err_out is tied 0.

## Structure
- control_pkg holds opcode_t enum, state_t enum (FETCH, DECODE, EXECUTE, HALT), and SEL_A_MEM/SEL_A_ALU/SEL_A_IMM constants.
- Sub-module return_stack: LIFO parametrised by WIDTH and DEPTH, with push, pop, full, empty, and top outputs.

## Test plan
- Reset then program {LDI 5, ADDI 3, STO 0x10, HLT}, ack every cycle:
  - acc_wr pulses at cycles 3 and 6;
  - data_memory_wr_out with operand_out=0x010 at cycle 9;
  - halted_out=1 at cycle 12.
- ack delayed 2 cycles per fetch: each instruction takes 5 cycles and the strobe sequence is unchanged.
- BEQ 0x020 with Z=1 → address_out=0x020 next FETCH. With Z=0 → address_out=PC+1.
- CALL 0x040 at PC 0x005, then RET → fetch resumes at 0x006 (CONTROL_STACK_EN).
- 5 nested CALLs with STACK_DEPTH=4 → stack_err_out=1 and HALT. RET on empty stack → same.
- reset_in low during EXECUTE of STO → strobe drops immediately and fetch restarts at 0x000.
